// File: rtl/reg_mmr_xvote_scrub.sv
// K_MMR-way redundant register with bitwise majority voting, cross-voted outputs,
// periodic scrub write-back of the vote and sticky per-copy error bookkeeping.
module reg_mmr_xvote_scrub #(
  parameter int                 K_MMR        = 3,
  parameter int                 WIDTH        = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE  = '0,
  parameter bit                 MISMATCH_EN  = 1'b1,
  parameter int                 SCRUB_PERIOD = 1,
  parameter int                 CNT_WIDTH    = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [K_MMR-1:0]                we_i,
  input  logic [K_MMR-1:0][WIDTH-1:0]     d_i,
  input  logic                            scrub_en_i,
  input  logic                            err_clr_i,
  output logic [K_MMR-1:0][WIDTH-1:0]     q_o,
  output logic                            scrub_o,
  output logic                            mismatch_o,
  output logic [K_MMR-1:0]                err_copy_o,
  output logic [CNT_WIDTH-1:0]            err_cnt_o
);

  localparam int               SC_W    = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SCRUB_PERIOD - 1);

  function automatic logic [WIDTH-1:0] majority(input logic [K_MMR-1:0][WIDTH-1:0] c);
    logic [WIDTH-1:0] v;
    int               ones;
    v = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int k = 0; k < K_MMR; k++) ones += int'(c[k][b]);
      v[b] = (ones > K_MMR / 2);
    end
    return v;
  endfunction

  logic [K_MMR-1:0][WIDTH-1:0] copy_q, copy_d;
  logic [SC_W-1:0]             sc_q, sc_d;
  logic                        scrub_q;
  logic [WIDTH-1:0]            scrub_vote;
  logic                        tick;

  // Scrub and error detection get their own voter, independent of the output voters.
  assign scrub_vote = majority(copy_q);
  assign tick       = scrub_en_i && (sc_q == SC_LAST);

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sc_d   = '0;
    copy_d = copy_q;
    if (scrub_en_i && (sc_q != SC_LAST)) sc_d = sc_q + 1'b1;
    for (int k = 0; k < K_MMR; k++) begin
      if (we_i[k])   copy_d[k] = d_i[k];
      else if (tick) copy_d[k] = scrub_vote;
    end
  end

  // NOTE: state uses non-blocking assignments so all copies update from the same pre-edge values.
  // NOTE: the copies are plain flops, not a RAM, so resetting them to RESET_VALUE is legal and required.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      copy_q  <= {K_MMR{RESET_VALUE}};
      sc_q    <= '0;
      scrub_q <= 1'b0;
    end else begin
      copy_q  <= copy_d;
      sc_q    <= sc_d;
      scrub_q <= tick;
    end
  end

  assign scrub_o = scrub_q;

  for (genvar i = 0; i < K_MMR - 2; i++) begin : g_voted_out
    logic [WIDTH-1:0] vote_w;
    assign vote_w = majority(copy_q);
    assign q_o[i] = vote_w;
  end
  assign q_o[K_MMR-2] = copy_q[K_MMR-2];
  assign q_o[K_MMR-1] = copy_q[K_MMR-1];

  if (MISMATCH_EN) begin : g_err
    logic [K_MMR-1:0]     diff;
    logic                 any;
    logic                 mm_q;
    logic [K_MMR-1:0]     errc_q, errc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      for (int k = 0; k < K_MMR; k++) diff[k] = (copy_q[k] != scrub_vote);
    end
    assign any = |diff;

    // A clear still records disagreements seen in the same cycle.
    always_comb begin
      errc_d = errc_q | diff;
      cnt_d  = cnt_q;
      if (err_clr_i) begin
        errc_d = diff;
        cnt_d  = any ? CNT_WIDTH'(1) : '0;
      end else if (any && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mm_q   <= 1'b0;
        errc_q <= '0;
        cnt_q  <= '0;
      end else begin
        mm_q   <= any;
        errc_q <= errc_d;
        cnt_q  <= cnt_d;
      end
    end

    assign mismatch_o = mm_q;
    assign err_copy_o = errc_q;
    assign err_cnt_o  = cnt_q;
  end else begin : g_no_err
    assign mismatch_o = 1'b0;
    assign err_copy_o = '0;
    assign err_cnt_o  = '0;
  end

endmodule

// File: tb/tb_reg_mmr_xvote_scrub.sv
// Bench for reg_mmr_xvote_scrub: hand table, corner sequences and random stimulus
// on three parameterisations, checked against a bit-counting reference model.
module tb_reg_mmr_xvote_scrub;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           we;
  logic [2:0][7:0]      d;
  logic                 en, clr;

  // A: period 4, 16-bit counter. B: period 1, 4-bit counter. C: period 4, no error logic.
  logic [2:0][7:0] qa, qb, qc;
  logic            sa, sb, sc, ma, mb, mc;
  logic [2:0]      ea, eb, ec;
  logic [15:0]     ca, cc;
  logic [3:0]      cb;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  reg_mmr_xvote_scrub #(.K_MMR(3), .WIDTH(8), .RESET_VALUE(8'h00), .MISMATCH_EN(1'b1),
                        .SCRUB_PERIOD(4), .CNT_WIDTH(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .we_i(we), .d_i(d), .scrub_en_i(en), .err_clr_i(clr),
    .q_o(qa), .scrub_o(sa), .mismatch_o(ma), .err_copy_o(ea), .err_cnt_o(ca));

  reg_mmr_xvote_scrub #(.K_MMR(3), .WIDTH(8), .RESET_VALUE(8'h00), .MISMATCH_EN(1'b1),
                        .SCRUB_PERIOD(1), .CNT_WIDTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .we_i(we), .d_i(d), .scrub_en_i(en), .err_clr_i(clr),
    .q_o(qb), .scrub_o(sb), .mismatch_o(mb), .err_copy_o(eb), .err_cnt_o(cb));

  reg_mmr_xvote_scrub #(.K_MMR(3), .WIDTH(8), .RESET_VALUE(8'h00), .MISMATCH_EN(1'b0),
                        .SCRUB_PERIOD(4), .CNT_WIDTH(16)) dut_c (
    .clk_i(clk), .rst_i(rst), .we_i(we), .d_i(d), .scrub_en_i(en), .err_clr_i(clr),
    .q_o(qc), .scrub_o(sc), .mismatch_o(mc), .err_copy_o(ec), .err_cnt_o(cc));

  typedef struct packed {
    logic [2:0][7:0] cp;
    int unsigned     phase;
    logic            scrub;
    logic            mm;
    logic [2:0]      errc;
    int unsigned     cnt;
  } model_t;

  model_t ma_m, mb_m;

  function automatic logic [7:0] vote(input logic [2:0][7:0] cp);
    logic [7:0] v;
    int         ones;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int k = 0; k < 3; k++) if (cp[k][b]) ones++;
      v[b] = (2 * ones > 3);
    end
    return v;
  endfunction

  function automatic model_t step(input model_t m, input int unsigned period, input int unsigned cmax,
                                  input logic [2:0] w, input logic [2:0][7:0] dd,
                                  input logic e, input logic c);
    model_t     n;
    logic [7:0] v;
    logic       tk;
    logic [2:0] diff;
    n  = m;
    v  = vote(m.cp);
    tk = e && (m.phase == period - 1);
    for (int k = 0; k < 3; k++) begin
      diff[k] = (m.cp[k] != v);
      if (w[k])    n.cp[k] = dd[k];
      else if (tk) n.cp[k] = v;
    end
    n.phase = e ? ((m.phase + 1) % period) : 0;
    n.scrub = tk;
    n.mm    = |diff;
    n.errc  = c ? diff : (m.errc | diff);
    if (c)                      n.cnt = (|diff) ? 1 : 0;
    else if (|diff && m.cnt < cmax) n.cnt = m.cnt + 1;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [2:0] w, input logic [2:0][7:0] dd, input logic e, input logic c);
    we = w; d = dd; en = e; clr = c;
    @(posedge clk);
    ma_m = step(ma_m, 4, 32'hFFFF, w, dd, e, c);
    mb_m = step(mb_m, 1, 15, w, dd, e, c);
    #1;
  endtask

  task automatic compare_model(input string tag);
    logic [7:0] va, vb;
    va = vote(ma_m.cp);
    vb = vote(mb_m.cp);
    check({tag, " a.q0"}, 32'(qa[0]), 32'(va));
    check({tag, " a.q1"}, 32'(qa[1]), 32'(ma_m.cp[1]));
    check({tag, " a.q2"}, 32'(qa[2]), 32'(ma_m.cp[2]));
    check({tag, " a.scrub"}, 32'(sa), 32'(ma_m.scrub));
    check({tag, " a.mm"}, 32'(ma), 32'(ma_m.mm));
    check({tag, " a.errc"}, 32'(ea), 32'(ma_m.errc));
    check({tag, " a.cnt"}, 32'(ca), ma_m.cnt);
    check({tag, " b.q0"}, 32'(qb[0]), 32'(vb));
    check({tag, " b.q1"}, 32'(qb[1]), 32'(mb_m.cp[1]));
    check({tag, " b.q2"}, 32'(qb[2]), 32'(mb_m.cp[2]));
    check({tag, " b.scrub"}, 32'(sb), 32'(mb_m.scrub));
    check({tag, " b.mm"}, 32'(mb), 32'(mb_m.mm));
    check({tag, " b.errc"}, 32'(eb), 32'(mb_m.errc));
    check({tag, " b.cnt"}, 32'(cb), mb_m.cnt);
    check({tag, " c.q"}, 32'(qc), {8'h00, ma_m.cp[2], ma_m.cp[1], va});
    check({tag, " c.scrub"}, 32'(sc), 32'(ma_m.scrub));
    check({tag, " c.err"}, {11'd0, mc, ec, cc}, 32'd0);
  endtask

  task automatic model_reset();
    ma_m = '0;
    mb_m = '0;
  endtask

  typedef struct packed {
    logic [2:0]      we;
    logic [2:0][7:0] d;
    logic            en;
    logic            clr;
    logic [7:0]      q0, q1, q2;
    logic            scrub;
    logic            mm;
    logic [2:0]      errc;
    logic [15:0]     cnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Expected values for dut_a (SCRUB_PERIOD = 4), one row per clock edge.
    tbl[0]  = '{3'b111, {8'hA5, 8'hA5, 8'hA5}, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b000, 16'd0};
    tbl[1]  = '{3'b010, {8'h00, 8'h25, 8'h00}, 1'b0, 1'b0, 8'hA5, 8'h25, 8'hA5, 1'b0, 1'b0, 3'b000, 16'd0};
    tbl[2]  = '{3'b000, 24'h0,                 1'b0, 1'b0, 8'hA5, 8'h25, 8'hA5, 1'b0, 1'b1, 3'b010, 16'd1};
    tbl[3]  = '{3'b000, 24'h0,                 1'b0, 1'b0, 8'hA5, 8'h25, 8'hA5, 1'b0, 1'b1, 3'b010, 16'd2};
    tbl[4]  = '{3'b000, 24'h0,                 1'b1, 1'b0, 8'hA5, 8'h25, 8'hA5, 1'b0, 1'b1, 3'b010, 16'd3};
    tbl[5]  = '{3'b000, 24'h0,                 1'b1, 1'b0, 8'hA5, 8'h25, 8'hA5, 1'b0, 1'b1, 3'b010, 16'd4};
    tbl[6]  = '{3'b000, 24'h0,                 1'b1, 1'b0, 8'hA5, 8'h25, 8'hA5, 1'b0, 1'b1, 3'b010, 16'd5};
    tbl[7]  = '{3'b000, 24'h0,                 1'b1, 1'b0, 8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b1, 3'b010, 16'd6};
    tbl[8]  = '{3'b000, 24'h0,                 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b010, 16'd6};
    tbl[9]  = '{3'b000, 24'h0,                 1'b0, 1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b000, 16'd0};
    tbl[10] = '{3'b100, {8'h0F, 8'h00, 8'h00}, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'h0F, 1'b0, 1'b0, 3'b000, 16'd0};
    tbl[11] = '{3'b000, 24'h0,                 1'b0, 1'b0, 8'hA5, 8'hA5, 8'h0F, 1'b0, 1'b1, 3'b100, 16'd1};
    tbl[12] = '{3'b000, 24'h0,                 1'b0, 1'b0, 8'hA5, 8'hA5, 8'h0F, 1'b0, 1'b1, 3'b100, 16'd2};
    tbl[13] = '{3'b000, 24'h0,                 1'b0, 1'b1, 8'hA5, 8'hA5, 8'h0F, 1'b0, 1'b1, 3'b100, 16'd1};
    tbl[14] = '{3'b100, {8'hA5, 8'h00, 8'h00}, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b1, 3'b100, 16'd2};
    tbl[15] = '{3'b000, 24'h0,                 1'b0, 1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b000, 16'd0};

    rst = 1'b1; we = '0; d = '0; en = 1'b0; clr = 1'b0;
    model_reset();
    #3;
    compare_model("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].we, tbl[i].d, tbl[i].en, tbl[i].clr);
      check($sformatf("tbl%0d q0", i),    32'(qa[0]), 32'(tbl[i].q0));
      check($sformatf("tbl%0d q1", i),    32'(qa[1]), 32'(tbl[i].q1));
      check($sformatf("tbl%0d q2", i),    32'(qa[2]), 32'(tbl[i].q2));
      check($sformatf("tbl%0d scrub", i), 32'(sa),    32'(tbl[i].scrub));
      check($sformatf("tbl%0d mm", i),    32'(ma),    32'(tbl[i].mm));
      check($sformatf("tbl%0d errc", i),  32'(ea),    32'(tbl[i].errc));
      check($sformatf("tbl%0d cnt", i),   32'(ca),    32'(tbl[i].cnt));
      compare_model($sformatf("tbl%0d", i));
    end

    // Long minority upset on copy 0: dut_b's 4-bit counter must saturate at 15.
    cycle(3'b001, {8'h00, 8'h00, 8'h11}, 1'b0, 1'b0);
    compare_model("sat_w");
    for (int i = 0; i < 18; i++) begin
      cycle(3'b000, 24'h0, 1'b0, 1'b0);
      compare_model($sformatf("sat%0d", i));
    end
    check("b_saturated", 32'(cb), 32'd15);
    check("a_cnt18", 32'(ca), 32'd18);

    // Clear while copy 0 still disagrees, then repair and clear again.
    cycle(3'b000, 24'h0, 1'b0, 1'b1);
    check("clr_mm_cnt", 32'(ca), 32'd1);
    check("clr_mm_errc", 32'(ea), 32'b001);
    compare_model("clr_mm");
    cycle(3'b001, {8'h00, 8'h00, 8'hA5}, 1'b0, 1'b0);
    compare_model("fix");
    cycle(3'b000, 24'h0, 1'b0, 1'b1);
    check("clr_ok_cnt", 32'(ca), 32'd0);
    check("clr_ok_errc", 32'(ea), 32'd0);
    compare_model("clr_ok");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]      rw;
      logic [2:0][7:0] rd;
      rw = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      rd = 24'($urandom);
      cycle(rw, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      compare_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of scrubbing with copies at 0x3C.
    cycle(3'b111, {8'h3C, 8'h3C, 8'h3C}, 1'b1, 1'b0);
    cycle(3'b001, {8'h00, 8'h00, 8'hFF}, 1'b1, 1'b0);
    cycle(3'b000, 24'h0, 1'b1, 1'b0);
    compare_model("pre_rst");
    check("pre_rst_b_scrub", 32'(sb), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_a_q", 32'(qa), 32'd0);
    check("async_rst_b_scrub", 32'(sb), 32'd0);
    compare_model("async_rst");
    #2;
    rst = 1'b0;
    cycle(3'b000, 24'h0, 1'b0, 1'b0);
    compare_model("post_rst");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_mmr_xvote_scrub.md
Name: reg_mmr_xvote_scrub

Overview:
- WIDTH-bit register replicated K_MMR times, with bitwise majority voting and cross-voted outputs.
- Two additions: periodic scrubbing, which writes the voted value back into every copy, and error bookkeeping (per-copy sticky flags plus a saturating mismatch-event counter).
- Used for configuration and state registers inside the TMR datapath, where single-event upsets must be corrected, not only masked.

Parameters:
- K_MMR, 3, number of redundant copies; odd, >=3.
- WIDTH, 8, bits per copy.
- RESET_VALUE, '0 (WIDTH bits), value loaded into every copy on reset.
- MISMATCH_EN, 1'b1, when 0 all error outputs are tied to 0 and the counter logic is removed.
- SCRUB_PERIOD, 1, number of cycles between scrub ticks while scrubbing is enabled; >=1.
- CNT_WIDTH, 16, width of the mismatch-event counter.

Ports:
- clk_i, input, 1, single clock for all copies.
- rst_i, input, 1, asynchronous active-high reset.
- we_i, input, K_MMR, per-copy write enable.
- d_i, input, K_MMR x WIDTH, per-copy write data.
- scrub_en_i, input, 1, enables periodic scrubbing.
- err_clr_i, input, 1, synchronous clear of err_copy_o and err_cnt_o.
- q_o, output, K_MMR x WIDTH, outputs; entries 0..K_MMR-3 are voted, entries K_MMR-2 and K_MMR-1 are raw copies K_MMR-2 and K_MMR-1 (so no single voter is a point of failure).
- scrub_o, output, 1, one-cycle pulse registered with the scrub write.
- mismatch_o, output, 1, registered: some copy disagreed with the vote in the previous cycle.
- err_copy_o, output, K_MMR, sticky: bit k is set once copy k has disagreed with the vote.
- err_cnt_o, output, CNT_WIDTH, saturating count of mismatch cycles.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - every copy = RESET_VALUE;
  - scrub period counter = 0;
  - scrub_o = 0, mismatch_o = 0, err_copy_o = 0, err_cnt_o = 0.
- Vote: vote[b] = 1 iff more than K_MMR/2 copies have bit b = 1. Purely combinational from the stored copies.
- Each voted output q_o[i] (i < K_MMR-2) uses its own voter instance; there is no shared voter.
- Scrub period counter:
  - held at 0 while scrub_en_i = 0;
  - otherwise increments each cycle and wraps to 0 after SCRUB_PERIOD-1.
  - tick = scrub_en_i && counter == SCRUB_PERIOD-1. With SCRUB_PERIOD = 1, tick = scrub_en_i.
- Copy update, per copy k, at each clock edge (priority order):
  1. we_i[k] = 1: copy k <= d_i[k];
  2. else tick = 1: copy k <= vote;
  3. else copy k holds.
  - A write and a tick in the same cycle: written copies take d_i; the other copies take the pre-write vote.
- scrub_o <= tick (a 1-cycle pulse aligned with the scrubbed contents).
- Latency:
  - raw q_o entries follow d_i one cycle after the write;
  - voted q_o entries follow once a majority of copies has been written;
  - mismatch_o and error flags lag the stored copies by one cycle.
- diff[k] = (copy k != vote), computed combinationally; any = OR of diff.
- mismatch_o <= any.
- err_copy_o:
  - err_clr_i = 1: err_copy_o <= diff (new disagreements are not lost);
  - otherwise: err_copy_o <= err_copy_o | diff.
- err_cnt_o:
  - err_clr_i = 1: err_cnt_o <= any ? 1 : 0;
  - else if any and err_cnt_o != all-ones: increment by 1;
  - at all-ones the counter saturates and holds (never wraps).
- Writes to all copies with identical data produce no mismatch. Writing only a minority of copies produces a mismatch until a scrub tick or a full write.
- MISMATCH_EN = 0: mismatch_o, err_copy_o and err_cnt_o are constant 0. Scrubbing is unaffected.

Test Plan:
- Reset, then write 0xA5 to all 3 copies -> all q_o = 0xA5 next cycle; mismatch_o = 0; err_cnt_o = 0.
- With all copies 0xA5, force copy 1 to 0x25 via we_i = 3'b010, scrub_en_i = 0 -> voted q_o[0] = 0xA5; raw q_o[1] = 0x25; mismatch_o = 1 from the second cycle onward; err_copy_o = 3'b010; err_cnt_o increments by 1 per cycle.
- Same upset, then scrub_en_i = 1 with SCRUB_PERIOD = 4 -> scrub_o pulses on the 4th cycle after enable; copy 1 returns to 0xA5 at that edge; mismatch_o drops one cycle later; err_copy_o stays 3'b010.
- Preload err_cnt_o to 0xFFFE and hold a mismatch for 3 cycles -> count reaches 0xFFFF and stays there.
- Assert err_clr_i while copy 2 is still mismatched -> err_cnt_o = 1 and err_copy_o = 3'b100; with no mismatch, both clear to 0.
- Assert rst_i asynchronously mid-scrub with copies at 0x3C -> all outputs return to reset values immediately, without waiting for a clock edge; scrub_o = 0.
